// File: rtl/audio_mix_seq_if.sv
// Bundle of sound-source levels going into the mixer and the mixed stereo sample coming out.
interface audio_mix_seq_if;
  logic        mic, ear, speaker;
  logic [11:0] a1, b1, c1, a2, b2, c2;
  logic [7:0]  spdQ, sbxQ, sdvL1, sdvR1, sdvL2, sdvR2;
  logic [14:0] left, right;
  logic        strobe, busy;

  modport master (
    output mic, ear, speaker, a1, b1, c1, a2, b2, c2,
           spdQ, sbxQ, sdvL1, sdvR1, sdvL2, sdvR2,
    input  left, right, strobe, busy
  );
  modport slave (
    input  mic, ear, speaker, a1, b1, c1, a2, b2, c2,
           spdQ, sbxQ, sdvL1, sdvR1, sdvL2, sdvR2,
    output left, right, strobe, busy
  );
endinterface

// File: rtl/audio_mix_seq.sv
// Time-multiplexed stereo mixer: one L and one R accumulator stepped through every
// source once per output sample, emitting a coherent sample with a one-cycle strobe.
module audio_mix_seq #(
  parameter int DIV = 875
) (
  input  logic           clock,
  input  logic           reset,
  audio_mix_seq_if.slave mix
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  typedef struct packed {
    logic [11:0] a1, b1, c1, a2, b2, c2;
    logic [7:0]  spd, sbx, sdvl1, sdvr1, sdvl2, sdvr2, ula;
  } src_t;

  state_t      state, state_nxt;
  src_t        cap;
  logic [15:0] cnt;
  logic        tick;
  logic [3:0]  step;
  logic [15:0] acc_l, acc_r, term_l, term_r;
  logic [7:0]  ula_lvl;
  logic        busy_c, done_c;
  logic [14:0] left_q, right_q;
  logic        strobe_q;

  // free-running sample-rate divider
  always_ff @(posedge clock) begin
    if (reset)                   cnt <= '0;
    else if (cnt == 16'(DIV - 1)) cnt <= '0;
    else                         cnt <= cnt + 16'd1;
  end
  assign tick = (cnt == 16'(DIV - 1));

  always_comb begin
    ula_lvl = 8'h00;
    case ({mix.speaker, mix.ear, mix.mic})
      3'd0: ula_lvl = 8'h00;
      3'd1: ula_lvl = 8'h24;
      3'd2: ula_lvl = 8'h40;
      3'd3: ula_lvl = 8'h64;
      3'd4: ula_lvl = 8'hB8;
      3'd5: ula_lvl = 8'hC0;
      3'd6: ula_lvl = 8'hF8;
      default: ula_lvl = 8'hFF;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM: next state; a tick outside IDLE is simply dropped
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tick) state_nxt = ACC;
      ACC:     if (step == 4'd8) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy_c = (state != IDLE);
    done_c = (state == DONE);
  end

  // per-step addends, zero-extended to accumulator width
  always_comb begin
    term_l = '0;
    term_r = '0;
    case (step)
      4'd0: begin term_l = {3'b0, cap.a1, 1'b0};    term_r = {3'b0, cap.c1, 1'b0};    end
      4'd1: begin term_l = {3'b0, cap.a2, 1'b0};    term_r = {3'b0, cap.c2, 1'b0};    end
      4'd2: begin term_l = {4'b0, cap.b1};          term_r = {4'b0, cap.b1};          end
      4'd3: begin term_l = {4'b0, cap.b2};          term_r = {4'b0, cap.b2};          end
      4'd4: begin term_l = {3'b0, cap.spd, 5'b0};   term_r = {3'b0, cap.spd, 5'b0};   end
      4'd5: begin term_l = {3'b0, cap.sbx, 5'b0};   term_r = {3'b0, cap.sbx, 5'b0};   end
      4'd6: begin term_l = {3'b0, cap.sdvl1, 5'b0}; term_r = {3'b0, cap.sdvr1, 5'b0}; end
      4'd7: begin term_l = {3'b0, cap.sdvl2, 5'b0}; term_r = {3'b0, cap.sdvr2, 5'b0}; end
      4'd8: begin term_l = {4'b0, cap.ula, 4'b0};   term_r = {4'b0, cap.ula, 4'b0};   end
      default: ;
    endcase
  end

  // datapath; worst-case sum is 0xEF6A so no overflow handling is needed
  always_ff @(posedge clock) begin
    if (reset) begin
      cap      <= '0;
      step     <= '0;
      acc_l    <= '0;
      acc_r    <= '0;
      left_q   <= '0;
      right_q  <= '0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= done_c;
      case (state)
        IDLE: if (tick) begin
          cap   <= '{a1: mix.a1, b1: mix.b1, c1: mix.c1,
                     a2: mix.a2, b2: mix.b2, c2: mix.c2,
                     spd: mix.spdQ, sbx: mix.sbxQ,
                     sdvl1: mix.sdvL1, sdvr1: mix.sdvR1,
                     sdvl2: mix.sdvL2, sdvr2: mix.sdvR2,
                     ula: ula_lvl};
          step  <= '0;
          acc_l <= '0;
          acc_r <= '0;
        end
        ACC: begin
          acc_l <= acc_l + term_l;
          acc_r <= acc_r + term_r;
          step  <= step + 4'd1;
        end
        DONE: begin
          left_q  <= acc_l[15:1];
          right_q <= acc_r[15:1];
        end
        default: ;
      endcase
    end
  end

  assign mix.left   = left_q;
  assign mix.right  = right_q;
  assign mix.strobe = strobe_q;
  assign mix.busy   = busy_c;

endmodule
